// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: divides CLK into a one-cycle pixel tick. Horizontal and
// vertical timing FSMs step on that tick. They produce sync, blanking,
// coordinates and line/frame strobes. Everything is in the CLK domain.
module vga_timing_ctrl #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);

  // Last count of each horizontal phase; the FSM leaves a phase on these.
  localparam logic [CW-1:0] H_ACT_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_FP_LAST   = CW'(H_ACTIVE + H_FP - 1);
  localparam logic [CW-1:0] H_SYNC_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END   = CW'(H_ACTIVE);

  localparam logic [CW-1:0] V_ACT_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_FP_LAST   = CW'(V_ACTIVE + V_FP - 1);
  localparam logic [CW-1:0] V_SYNC_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_END   = CW'(V_ACTIVE);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCS, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCS, V_BACK} v_state_t;

  logic [DW-1:0] dcnt_reg;
  logic [CW-1:0] hcnt_reg, hcnt_next;
  logic [CW-1:0] vcnt_reg, vcnt_next;
  h_state_t      h_state_reg;
  v_state_t      v_state_reg;
  logic          hsync_reg, vsync_reg, video_on_reg;
  logic [CW-1:0] x_reg, y_reg;
  logic          tick, line_wrap, frame_wrap;

  // Reset is gated in so no tick or strobe escapes during a reset cycle.
  assign tick       = EN && !RST && (dcnt_reg == D_LAST);
  assign line_wrap  = tick && (hcnt_reg == H_LAST);
  assign frame_wrap = line_wrap && (vcnt_reg == V_LAST);

  assign pix_tick    = tick;
  assign line_start  = line_wrap;
  assign frame_start = frame_wrap;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign x           = x_reg;
  assign y           = y_reg;

  // Clock divider: free-runs while enabled and holds its phase when EN drops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dcnt_reg <= '0;
    end else if (EN) begin
      dcnt_reg <= (dcnt_reg == D_LAST) ? '0 : dcnt_reg + DW'(1);
    end
  end

  // Next pixel/line position; wraps only through the explicit terminal compare.
  always_comb begin
    hcnt_next = hcnt_reg;
    vcnt_next = vcnt_reg;
    if (tick) begin
      hcnt_next = (hcnt_reg == H_LAST) ? '0 : hcnt_reg + CW'(1);
    end
    if (line_wrap) begin
      vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + CW'(1);
    end
  end

  // Position counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else begin
      hcnt_reg <= hcnt_next;
      vcnt_reg <= vcnt_next;
    end
  end

  // Horizontal phase FSM; hsync is registered on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      h_state_reg <= H_ACT;
      hsync_reg   <= ~HS_POL;
    end else if (tick) begin
      case (h_state_reg)
        H_ACT:   if (hcnt_reg == H_ACT_LAST) h_state_reg <= H_FRONT;
        H_FRONT: if (hcnt_reg == H_FP_LAST) begin
                   h_state_reg <= H_SYNCS;
                   hsync_reg   <= HS_POL;
                 end
        H_SYNCS: if (hcnt_reg == H_SYNC_LAST) begin
                   h_state_reg <= H_BACK;
                   hsync_reg   <= ~HS_POL;
                 end
        H_BACK:  if (hcnt_reg == H_LAST) h_state_reg <= H_ACT;
        default: begin
                   h_state_reg <= H_ACT;
                   hsync_reg   <= ~HS_POL;
                 end
      endcase
    end
  end

  // Vertical phase FSM; advances once per line, on the horizontal wrap tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_state_reg <= V_ACT;
      vsync_reg   <= ~VS_POL;
    end else if (line_wrap) begin
      case (v_state_reg)
        V_ACT:   if (vcnt_reg == V_ACT_LAST) v_state_reg <= V_FRONT;
        V_FRONT: if (vcnt_reg == V_FP_LAST) begin
                   v_state_reg <= V_SYNCS;
                   vsync_reg   <= VS_POL;
                 end
        V_SYNCS: if (vcnt_reg == V_SYNC_LAST) begin
                   v_state_reg <= V_BACK;
                   vsync_reg   <= ~VS_POL;
                 end
        V_BACK:  if (vcnt_reg == V_LAST) v_state_reg <= V_ACT;
        default: begin
                   v_state_reg <= V_ACT;
                   vsync_reg   <= ~VS_POL;
                 end
      endcase
    end
  end

  // Coordinate and blanking registers, loaded from next-state counts so they stay aligned with sync.
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_reg        <= '0;
      y_reg        <= '0;
      video_on_reg <= 1'b1;
    end else begin
      x_reg        <= hcnt_next;
      y_reg        <= vcnt_next;
      video_on_reg <= (hcnt_next < H_ACT_END) && (vcnt_next < V_ACT_END);
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl: two reduced-size instances are checked
// every cycle against a position-arithmetic reference model.
module tb_vga_timing_ctrl;

  // Instance 0: small raster, DIV=3, active-low hsync, active-high vsync.
  localparam int D0_DIV = 3;
  localparam int D0_HA = 20, D0_HFP = 4, D0_HS = 6, D0_HBP = 5;
  localparam int D0_VA = 10, D0_VFP = 2, D0_VS = 2, D0_VBP = 3;
  // Instance 1: full-width line, DIV=1, active-high hsync, few lines per frame.
  localparam int D1_DIV = 1;
  localparam int D1_HA = 640, D1_HFP = 16, D1_HS = 96, D1_HBP = 48;
  localparam int D1_VA = 4, D1_VFP = 1, D1_VS = 1, D1_VBP = 1;

  localparam int N_CYC = 24000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en0, en1;
  logic pt0, hs0, vs0, vo0, ls0, fs0;
  logic [5:0] x0, y0;
  logic pt1, hs1, vs1, vo1, ls1, fs1;
  logic [9:0] x1, y1;

  vga_timing_ctrl #(
    .DIV(D0_DIV), .H_ACTIVE(D0_HA), .H_FP(D0_HFP), .H_SYNC(D0_HS), .H_BP(D0_HBP),
    .V_ACTIVE(D0_VA), .V_FP(D0_VFP), .V_SYNC(D0_VS), .V_BP(D0_VBP),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(6)
  ) dut0 (
    .CLK(clk), .RST(rst), .EN(en0), .pix_tick(pt0), .hsync(hs0), .vsync(vs0),
    .video_on(vo0), .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_ctrl #(
    .DIV(D1_DIV), .H_ACTIVE(D1_HA), .H_FP(D1_HFP), .H_SYNC(D1_HS), .H_BP(D1_HBP),
    .V_ACTIVE(D1_VA), .V_FP(D1_VFP), .V_SYNC(D1_VS), .V_BP(D1_VBP),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(10)
  ) dut1 (
    .CLK(clk), .RST(rst), .EN(en1), .pix_tick(pt1), .hsync(hs1), .vsync(vs1),
    .video_on(vo1), .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
  );

  int p_div[2] = '{D0_DIV, D1_DIV};
  int p_ha[2]  = '{D0_HA, D1_HA};
  int p_hfp[2] = '{D0_HFP, D1_HFP};
  int p_hs[2]  = '{D0_HS, D1_HS};
  int p_hbp[2] = '{D0_HBP, D1_HBP};
  int p_va[2]  = '{D0_VA, D1_VA};
  int p_vfp[2] = '{D0_VFP, D1_VFP};
  int p_vs[2]  = '{D0_VS, D1_VS};
  int p_vbp[2] = '{D0_VBP, D1_VBP};
  bit p_hpol[2] = '{1'b0, 1'b1};
  bit p_vpol[2] = '{1'b1, 1'b0};

  // Model state: divider phase and raster position per instance.
  int m_d[2], m_h[2], m_v[2];
  int n_ls_exp[2], n_fs_exp[2], n_ls_obs[2], n_fs_obs[2];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input bit en_i, input logic pt, input logic hs,
                           input logic vs, input logic vo, input logic ls, input logic fs,
                           input logic [31:0] xo, input logic [31:0] yo);
    int  ht, vt;
    bit  pt_e, ls_e, fs_e, hs_e, vs_e, vo_e;
    string pre;
    pre  = (d == 0) ? "d0_" : "d1_";
    ht   = p_ha[d] + p_hfp[d] + p_hs[d] + p_hbp[d];
    vt   = p_va[d] + p_vfp[d] + p_vs[d] + p_vbp[d];
    pt_e = en_i && !rst && (m_d[d] == p_div[d] - 1);
    ls_e = pt_e && (m_h[d] == ht - 1);
    fs_e = ls_e && (m_v[d] == vt - 1);
    hs_e = (m_h[d] >= p_ha[d] + p_hfp[d] && m_h[d] < p_ha[d] + p_hfp[d] + p_hs[d])
           ? p_hpol[d] : !p_hpol[d];
    vs_e = (m_v[d] >= p_va[d] + p_vfp[d] && m_v[d] < p_va[d] + p_vfp[d] + p_vs[d])
           ? p_vpol[d] : !p_vpol[d];
    vo_e = (m_h[d] < p_ha[d]) && (m_v[d] < p_va[d]);
    check({pre, "pix_tick"}, 32'(pt), 32'(pt_e));
    check({pre, "line_start"}, 32'(ls), 32'(ls_e));
    check({pre, "frame_start"}, 32'(fs), 32'(fs_e));
    check({pre, "hsync"}, 32'(hs), 32'(hs_e));
    check({pre, "vsync"}, 32'(vs), 32'(vs_e));
    check({pre, "video_on"}, 32'(vo), 32'(vo_e));
    check({pre, "x"}, xo, 32'(m_h[d]));
    check({pre, "y"}, yo, 32'(m_v[d]));
    if (ls === 1'b1) n_ls_obs[d]++;
    if (fs === 1'b1) n_fs_obs[d]++;
    if (ls_e) n_ls_exp[d]++;
    if (fs_e) n_fs_exp[d]++;
  endtask

  // Advance the model by one CLK edge using the inputs applied this cycle.
  task automatic model_step(input int d, input bit en_i);
    int ht, vt;
    ht = p_ha[d] + p_hfp[d] + p_hs[d] + p_hbp[d];
    vt = p_va[d] + p_vfp[d] + p_vs[d] + p_vbp[d];
    if (rst) begin
      m_d[d] = 0; m_h[d] = 0; m_v[d] = 0;
    end else if (en_i) begin
      if (m_d[d] == p_div[d] - 1) begin
        m_d[d] = 0;
        if (m_h[d] == ht - 1) begin
          m_h[d] = 0;
          m_v[d] = (m_v[d] == vt - 1) ? 0 : m_v[d] + 1;
        end else begin
          m_h[d] = m_h[d] + 1;
        end
      end else begin
        m_d[d] = m_d[d] + 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en0 = 1'b1; en1 = 1'b1;
    repeat (3) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_d[d] = 0; m_h[d] = 0; m_v[d] = 0;
      n_ls_exp[d] = 0; n_fs_exp[d] = 0; n_ls_obs[d] = 0; n_fs_obs[d] = 0;
    end
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      rst = (cyc < 3) || (cyc == 15000) || ($urandom_range(0, 4999) == 0);
      en0 = (cyc >= 5000 && cyc < 5050) ? 1'b0 : ($urandom_range(0, 99) >= 8);
      en1 = (cyc >= 9000 && cyc < 9050) ? 1'b0 : ($urandom_range(0, 99) >= 6);
      if (cyc < 6) begin
        en0 = 1'b1;
        en1 = 1'b1;
      end
      #1;
      check_dut(0, en0, pt0, hs0, vs0, vo0, ls0, fs0, 32'(x0), 32'(y0));
      check_dut(1, en1, pt1, hs1, vs1, vo1, ls1, fs1, 32'(x1), 32'(y1));
      model_step(0, en0);
      model_step(1, en1);
    end
    for (int d = 0; d < 2; d++) begin
      check((d == 0) ? "d0_line_count" : "d1_line_count", 32'(n_ls_obs[d]), 32'(n_ls_exp[d]));
      check((d == 0) ? "d0_frame_count" : "d1_frame_count", 32'(n_fs_obs[d]), 32'(n_fs_exp[d]));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
